// File: rtl/compositor_pkg.sv
// rtl/compositor_pkg.sv - shared types and constants for the beam compositor
package compositor_pkg;
   localparam int COLOR_W = 4;

   typedef logic [2:0][COLOR_W-1:0] rgb_t;

   typedef enum logic {
      IDLE,
      FLASH
   } flash_state_t;

   localparam int CH_R = 0;
   localparam int CH_G = 1;
   localparam int CH_B = 2;
endpackage

// File: rtl/flash_fsm.sv
// rtl/flash_fsm.sv - frame-counted flash state machine
module flash_fsm
   import compositor_pkg::*;
#(
   parameter int FLASH_FRAMES = 8
) (
   input  logic clk,
   input  logic reset,
   input  logic frame_start_i,
   input  logic flash_req_i,
   output logic flash_active_o
);
   localparam int CNT_W = $clog2(FLASH_FRAMES + 1);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FLASH_FRAMES);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   flash_state_t     state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // A request always reloads, so a coincident frame_start is swallowed.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (flash_req_i) begin
         state_d = FLASH;
         cnt_d   = CNT_LOAD;
      end else if (state_q == FLASH && frame_start_i) begin
         if (cnt_q == CNT_ONE) begin
            state_d = IDLE;
            cnt_d   = '0;
         end else begin
            cnt_d = cnt_q - CNT_ONE;
         end
      end
   end

   assign flash_active_o = (state_q == FLASH);
endmodule

// File: rtl/layered_beam_compositor.sv
// rtl/layered_beam_compositor.sv - two-stage layer/background compositor with flash; SCANLINE_EN dims odd rows
module layered_beam_compositor #(
   parameter int NUM_LAYERS   = 4,
   parameter int COLOR_W      = 4,
   parameter int X_W          = 11,
   parameter int Y_W          = 10,
   parameter int FIELD_X_MIN  = 341,
   parameter int FIELD_X_MAX  = 682,
   parameter int FLASH_FRAMES = 8
) (
   input  logic                                     clk,
   input  logic                                     reset,
   input  logic [NUM_LAYERS-1:0][2:0][COLOR_W-1:0] layer_color,
   input  logic [NUM_LAYERS-1:0]                    layer_transparency,
   input  logic [2:0][COLOR_W-1:0]                  bg_color,
   input  logic [X_W-1:0]                           beam_x,
   input  logic [Y_W-1:0]                           beam_y,
   input  logic                                     draw,
   input  logic                                     frame_start,
   input  logic                                     flash_req,
   output logic [COLOR_W-1:0]                       red,
   output logic [COLOR_W-1:0]                       green,
   output logic [COLOR_W-1:0]                       blue,
   output logic                                     draw_out,
   output logic                                     flash_active
);
   import compositor_pkg::CH_R;
   import compositor_pkg::CH_G;
   import compositor_pkg::CH_B;

   localparam logic [X_W-1:0] X_LO = X_W'(FIELD_X_MIN);
   localparam logic [X_W-1:0] X_HI = X_W'(FIELD_X_MAX);

   logic [2:0][COLOR_W-1:0] sel_q, sel_d;
   logic [2:0][COLOR_W-1:0] pix_q, pix_d;
   logic                    in_field_q, in_field_d;
   logic                    draw_q, draw_out_q;

   flash_fsm #(.FLASH_FRAMES(FLASH_FRAMES)) u_flash_fsm (
      .clk            (clk),
      .reset          (reset),
      .frame_start_i  (frame_start),
      .flash_req_i    (flash_req),
      .flash_active_o (flash_active)
   );

   // Walk from lowest priority upward so the lowest opaque index wins.
   always_comb begin
      sel_d = bg_color;
      for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
         if (!layer_transparency[i]) sel_d = layer_color[i];
      end
      in_field_d = draw && (beam_x >= X_LO) && (beam_x < X_HI);
   end

`ifdef SCANLINE_EN
   logic y_odd_q;

   always_ff @(posedge clk) begin
      if (reset) y_odd_q <= 1'b0;
      else       y_odd_q <= beam_y[0];
   end
`else
   logic unused_beam_y;
   assign unused_beam_y = ^beam_y;
`endif

   always_comb begin
      pix_d = '0;
      if (draw_q && in_field_q) begin
         pix_d = flash_active ? ~sel_q : sel_q;
`ifdef SCANLINE_EN
         if (y_odd_q) begin
            for (int c = 0; c < 3; c++) pix_d[c] = pix_d[c] >> 1;
         end
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sel_q      <= '0;
         in_field_q <= 1'b0;
         draw_q     <= 1'b0;
         pix_q      <= '0;
         draw_out_q <= 1'b0;
      end else begin
         sel_q      <= sel_d;
         in_field_q <= in_field_d;
         draw_q     <= draw;
         pix_q      <= pix_d;
         draw_out_q <= draw_q;
      end
   end

   assign red      = pix_q[CH_R];
   assign green    = pix_q[CH_G];
   assign blue     = pix_q[CH_B];
   assign draw_out = draw_out_q;
endmodule

// File: tb/tb_layered_beam_compositor.sv
// tb/tb_layered_beam_compositor.sv - randomized self-checking bench for layered_beam_compositor
module tb_layered_beam_compositor;
   logic                  clk = 1'b0;
   logic                  reset;
   logic [3:0][2:0][3:0]  layer_color;
   logic [3:0]            layer_transparency;
   logic [2:0][3:0]       bg_color;
   logic [10:0]           beam_x;
   logic [9:0]            beam_y;
   logic                  draw, frame_start, flash_req;
   logic [3:0]            red, green, blue;
   logic                  draw_out, flash_active;

   int total = 0;
   int bad   = 0;

   // reference state
   bit        m_flash = 0;
   int        m_left  = 0;
   logic [11:0] prev_rgb  = '0;
   logic        prev_draw = 1'b0;
   logic [11:0] exp_rgb;
   logic        exp_draw, exp_flash;

   layered_beam_compositor dut (
      .clk                (clk),
      .reset              (reset),
      .layer_color        (layer_color),
      .layer_transparency (layer_transparency),
      .bg_color           (bg_color),
      .beam_x             (beam_x),
      .beam_y             (beam_y),
      .draw               (draw),
      .frame_start        (frame_start),
      .flash_req          (flash_req),
      .red                (red),
      .green              (green),
      .blue               (blue),
      .draw_out           (draw_out),
      .flash_active       (flash_active)
   );

   always #5 clk = ~clk;

   function automatic logic [11:0] model_pixel(logic drw, int x, int y, bit fl);
      logic [3:0] ch [3];
      int sel = -1;
      if (!drw || x < 341 || x >= 682) return 12'h000;
      for (int i = 0; i < 4; i++) if (sel < 0 && !layer_transparency[i]) sel = i;
      for (int c = 0; c < 3; c++) begin
         ch[c] = (sel < 0) ? bg_color[c] : layer_color[sel][c];
         if (fl) ch[c] = 4'hF - ch[c];
`ifdef SCANLINE_EN
         if (y % 2 == 1) ch[c] = ch[c] / 2;
`endif
      end
      return {ch[0], ch[1], ch[2]};
   endfunction

   function automatic logic [2:0][3:0] mk(logic [3:0] r, logic [3:0] g, logic [3:0] b);
      logic [2:0][3:0] v;
      v[0] = r; v[1] = g; v[2] = b;
      return v;
   endfunction

   // Drives one pixel, advances the clock and leaves the expectation for the pixel now at the outputs.
   task automatic drive_cycle(input logic rst, input logic drw, input int x, input int y,
                              input logic fs, input logic fr);
      logic [11:0] e;
      @(negedge clk);
      reset = rst; draw = drw; beam_x = 11'(x); beam_y = 10'(y);
      frame_start = fs; flash_req = fr;
      if (rst) begin
         m_flash = 0; m_left = 0;
      end else if (fr) begin
         m_flash = 1; m_left = 8;
      end else if (m_flash && fs) begin
         m_left--;
         if (m_left == 0) m_flash = 0;
      end
      e = model_pixel(drw, x, y, m_flash);
      if (rst) begin
         e = '0; prev_rgb = '0; prev_draw = 1'b0;
      end
      @(posedge clk); #1;
      exp_rgb   = prev_rgb;
      exp_draw  = prev_draw;
      exp_flash = m_flash;
      prev_rgb  = e;
      prev_draw = rst ? 1'b0 : drw;
   endtask

   task automatic test_reset();
      layer_transparency = 4'hF; bg_color = mk(4'h3, 4'h5, 4'h7);
      for (int i = 0; i < 3; i++) begin
         drive_cycle(1, 1, 500, 0, 0, 1);
         total++;
         if ({red, green, blue} !== 12'h000 || draw_out !== 1'b0 || flash_active !== 1'b0) begin
            bad++;
            $display("FAIL reset: rgb=%h draw_out=%b flash=%b want 000/0/0", {red, green, blue}, draw_out, flash_active);
         end
      end
   endtask

   task automatic test_border();
      int xs [9] = '{340, 341, 681, 682, 500, 0, 2047, 500, 500};
      layer_transparency = 4'hF; bg_color = mk(4'h3, 4'h5, 4'h7);
      for (int i = 0; i < 9; i++) begin
         drive_cycle(0, 1, xs[i], 0, 0, 0);
         total++;
         if ({red, green, blue} !== exp_rgb || draw_out !== exp_draw) begin
            bad++;
            $display("FAIL border[%0d]: rgb=%h draw_out=%b want %h/%b", i, {red, green, blue}, draw_out, exp_rgb, exp_draw);
         end
      end
      total++;
      if ({red, green, blue} !== 12'h357) begin
         bad++;
         $display("FAIL border_const: rgb=%h want 357", {red, green, blue});
      end
   endtask

   task automatic test_priority();
      layer_color[1] = mk(4'hF, 4'h0, 4'h0);
      layer_color[2] = mk(4'h0, 4'hF, 4'h0);
      layer_color[0] = mk(4'h0, 4'h0, 4'hF);
      layer_transparency = 4'b1001;
      for (int i = 0; i < 6; i++) begin
         if (i == 3) layer_transparency = 4'b1000;
         drive_cycle(0, 1, 500, 0, 0, 0);
         total++;
         if ({red, green, blue} !== exp_rgb || draw_out !== exp_draw) begin
            bad++;
            $display("FAIL priority[%0d]: rgb=%h want %h", i, {red, green, blue}, exp_rgb);
         end
      end
      total++;
      if ({red, green, blue} !== 12'h00F) begin
         bad++;
         $display("FAIL priority_const: rgb=%h want 00F", {red, green, blue});
      end
   endtask

   task automatic test_draw_low();
      layer_transparency = 4'b0000;
      for (int i = 0; i < 6; i++) begin
         drive_cycle(0, (i % 2 == 1), 500, 0, 0, 0);
         total++;
         if ({red, green, blue} !== exp_rgb || draw_out !== exp_draw) begin
            bad++;
            $display("FAIL draw_low[%0d]: rgb=%h draw_out=%b want %h/%b", i, {red, green, blue}, draw_out, exp_rgb, exp_draw);
         end
      end
   endtask

   task automatic test_flash();
      layer_transparency = 4'hF; bg_color = mk(4'h3, 4'h5, 4'h7);
      for (int f = 0; f <= 8; f++) begin
         for (int k = 0; k < 4; k++) begin
            drive_cycle(0, 1, 500, 0, (f > 0 && k == 0), (f == 0 && k == 0));
            total++;
            if ({red, green, blue} !== exp_rgb || flash_active !== exp_flash || draw_out !== exp_draw) begin
               bad++;
               $display("FAIL flash[%0d.%0d]: rgb=%h flash=%b want %h/%b", f, k, {red, green, blue}, flash_active, exp_rgb, exp_flash);
            end
            if (f == 0 && k == 2) begin
               total++;
               if ({red, green, blue} !== 12'hCA8 || flash_active !== 1'b1) begin
                  bad++;
                  $display("FAIL flash_on: rgb=%h flash=%b want CA8/1", {red, green, blue}, flash_active);
               end
            end
         end
      end
      total++;
      if ({red, green, blue} !== 12'h357 || flash_active !== 1'b0) begin
         bad++;
         $display("FAIL flash_off: rgb=%h flash=%b want 357/0", {red, green, blue}, flash_active);
      end
   endtask

   task automatic test_retrigger_reset();
      int cnt_frames = 0;
      drive_cycle(0, 1, 500, 0, 0, 1);
      for (int f = 1; f <= 14; f++) begin
         for (int k = 0; k < 2; k++) begin
            drive_cycle(0, 1, 500, 0, (k == 0), (k == 0 && f == 5));
            total++;
            if ({red, green, blue} !== exp_rgb || flash_active !== exp_flash) begin
               bad++;
               $display("FAIL retrig[%0d.%0d]: rgb=%h flash=%b want %h/%b", f, k, {red, green, blue}, flash_active, exp_rgb, exp_flash);
            end
         end
         if (flash_active) cnt_frames++;
      end
      total++;
      if (cnt_frames !== 12) begin
         bad++;
         $display("FAIL retrig_len: frames_active=%0d want 12", cnt_frames);
      end
      drive_cycle(0, 1, 500, 0, 0, 1);
      drive_cycle(0, 1, 500, 0, 0, 0);
      drive_cycle(1, 1, 500, 0, 0, 0);
      total++;
      if ({red, green, blue} !== 12'h000 || draw_out !== 1'b0 || flash_active !== 1'b0) begin
         bad++;
         $display("FAIL reset_mid: rgb=%h draw_out=%b flash=%b want 000/0/0", {red, green, blue}, draw_out, flash_active);
      end
      for (int i = 0; i < 3; i++) begin
         drive_cycle(0, 1, 500, 0, 0, 0);
         total++;
         if ({red, green, blue} !== exp_rgb || draw_out !== exp_draw || flash_active !== exp_flash) begin
            bad++;
            $display("FAIL post_reset[%0d]: rgb=%h draw_out=%b want %h/%b", i, {red, green, blue}, draw_out, exp_rgb, exp_draw);
         end
      end
   endtask

   task automatic test_scanline();
      layer_transparency = 4'b1110;
      layer_color[0] = mk(4'hF, 4'h8, 4'h3);
      for (int i = 0; i < 4; i++) begin
         drive_cycle(0, 1, 400, (i < 2) ? 11 : 10, 0, 0);
         total++;
         if ({red, green, blue} !== exp_rgb) begin
            bad++;
            $display("FAIL scanline[%0d]: rgb=%h want %h", i, {red, green, blue}, exp_rgb);
         end
      end
`ifdef SCANLINE_EN
      total++;
      if ({red, green, blue} !== 12'hF83) begin
         bad++;
         $display("FAIL scanline_even: rgb=%h want F83", {red, green, blue});
      end
`endif
   endtask

   task automatic test_random();
      for (int i = 0; i < 600; i++) begin
         layer_color        = {$urandom, $urandom};
         layer_transparency = 4'($urandom);
         bg_color           = 12'($urandom);
         drive_cycle(($urandom_range(0, 99) == 0), ($urandom_range(0, 5) != 0),
                     (i % 7 == 0) ? $urandom_range(0, 2047) : $urandom_range(330, 690),
                     $urandom_range(0, 1023), ($urandom_range(0, 7) == 0), ($urandom_range(0, 40) == 0));
         total++;
         if ({red, green, blue} !== exp_rgb || draw_out !== exp_draw || flash_active !== exp_flash) begin
            bad++;
            $display("FAIL random[%0d]: rgb=%h draw_out=%b flash=%b want %h/%b/%b", i, {red, green, blue}, draw_out, flash_active, exp_rgb, exp_draw, exp_flash);
         end
      end
   endtask

   initial begin
      reset = 1'b1; draw = 1'b0; beam_x = '0; beam_y = '0;
      frame_start = 1'b0; flash_req = 1'b0;
      layer_color = '0; layer_transparency = 4'hF; bg_color = '0;
      test_reset();
      test_border();
      test_priority();
      test_draw_low();
      test_flash();
      test_retrigger_reset();
      test_scanline();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/layered_beam_compositor.md
Name: layered_beam_compositor

Overview:
- Per-pixel colour compositor at the end of the video path, between the sprite/layer renderers and the VGA DAC pins.
- Merges NUM_LAYERS sprite layers over a programmable background, inside a configurable playfield window, with a black border outside it.
- Output is registered with a fixed 2-cycle latency.
- Adds a frame-counted flash (colour-invert) effect driven by a small state machine.

Parameters:
- NUM_LAYERS, 4, number of sprite layers; index 0 has the highest priority.
- COLOR_W, 4, bits per colour channel.
- X_W, 11, width of beam_x.
- Y_W, 10, width of beam_y.
- FIELD_X_MIN, 341, first visible playfield column (inclusive).
- FIELD_X_MAX, 682, end of the playfield (exclusive).
- FLASH_FRAMES, 8, frames a flash lasts; must be >= 1.

Ports:
- clk  input  1  pixel clock
- reset  input  1  synchronous, active-high reset
- layer_color  input  [NUM_LAYERS][3][COLOR_W]  per-layer colour; channel order {0=R, 1=G, 2=B}
- layer_transparency  input  [NUM_LAYERS]  1 = layer transparent at this pixel
- bg_color  input  [3][COLOR_W]  playfield background colour
- beam_x  input  X_W  current column
- beam_y  input  Y_W  current row
- draw  input  1  beam is in the active video area
- frame_start  input  1  one-cycle pulse at the start of each frame
- flash_req  input  1  one-cycle pulse that starts or retriggers a flash
- red  output  COLOR_W  registered pixel red
- green  output  COLOR_W  registered pixel green
- blue  output  COLOR_W  registered pixel blue
- draw_out  output  1  draw delayed by 2 cycles, aligned with the colour outputs
- flash_active  output  1  high while the FSM is in FLASH

Behaviour:
- Reset: red, green, blue = 0; draw_out = 0; flash_active = 0; FSM = IDLE; frame counter = 0; all pipeline registers cleared. Reset mid-frame flushes the pipeline: the first two cycles after reset deasserts output 0 and draw_out = 0.
- Stage 1 (cycle N+1): register in_field = draw && (beam_x >= FIELD_X_MIN) && (beam_x < FIELD_X_MAX), using unsigned compares at X_W bits.
- Stage 1 also registers the selected colour:
  - the lowest-index layer with layer_transparency = 0;
  - if every layer is transparent, bg_color.
- Stage 1 also registers draw.
- Stage 2 (cycle N+2):
  - if !draw_d: output 0;
  - else if !in_field: output 0 (border);
  - else the selected colour, bitwise inverted per channel when flash_active is high.
- draw_out = draw_d, delayed a second cycle.
- Total latency is exactly 2 cycles, with throughput of 1 pixel per cycle.
- beam_y feeds only the optional feature; it is pipelined alongside the pixel.
- FSM:
  - IDLE: on flash_req, go to FLASH and load counter = FLASH_FRAMES.
  - FLASH: flash_req reloads counter = FLASH_FRAMES (retrigger).
  - FLASH, otherwise: frame_start decrements the counter; frame_start with counter == 1 goes to IDLE and sets counter = 0.
- Simultaneous flash_req and frame_start: the reload wins and no decrement happens that cycle.
- flash_active is registered from the FSM state. It takes effect on pixels entering stage 2 on the cycle after the state change; no mid-pipeline reordering.
- Counter width is $clog2(FLASH_FRAMES+1). With FLASH_FRAMES = 1 the flash ends on the first frame_start.

Optional Feature:
- Macro: SCANLINE_EN.
- Defined: in-field pixels on odd rows (beam_y[0] = 1, delayed with the pixel) have each channel logically shifted right by 1. The shift is applied after the flash inversion. Border and !draw pixels remain 0.
- Undefined: no row dependence; the beam_y pipeline register is removed.

Decomposition:
- Package compositor_pkg:
  - typedef rgb_t = logic [2:0][COLOR_W-1:0] (COLOR_W as a package localparam, default 4);
  - enum flash_state_t {IDLE, FLASH};
  - channel index constants CH_R = 0, CH_G = 1, CH_B = 2.
- One sub-module, flash_fsm: owns the state and the frame counter, and outputs flash_active.
- Layer priority selection and the pipeline stay in the top module.

Test Plan:
- Border and window: draw = 1, all layers transparent, bg = {3, 5, 7}.
  - beam_x = 340 -> output 0.
  - beam_x = 341 -> {3, 5, 7} two cycles later.
  - beam_x = 681 -> {3, 5, 7}.
  - beam_x = 682 -> output 0.
- Priority: beam_x = 500; layer 1 opaque {F, 0, 0}, layer 2 opaque {0, F, 0} -> {F, 0, 0}. Then make layer 0 opaque {0, 0, F} -> {0, 0, F}.
- draw low: draw = 0 with an opaque layer in the field -> output 0 and draw_out = 0, two cycles after the input.
- Flash: flash_req, then 8 frame_start pulses; in-field pixel {3, 5, 7}.
  - After the FSM enters FLASH -> {C, A, 8}, flash_active = 1.
  - After the 8th frame_start -> {3, 5, 7}, flash_active = 0.
- Retrigger and reset: flash_req coincident with the 5th frame_start -> the flash lasts 8 more frames. Assert reset mid-flash -> all outputs 0 and FSM IDLE on the next cycle.
- SCANLINE_EN: beam_y = 11, pixel {F, 8, 3} -> {7, 4, 1}. beam_y = 10 -> {F, 8, 3}.
